// File: rtl/dmem_bus_if_if.sv
// External data-memory bus: address, request, direction, size and acknowledge.
// The bidirectional data lines stay a plain inout port on the bus master.
interface dmem_bus_if_if #(
  parameter int unsigned BIT_WIDTH = 32
) ();
  logic [BIT_WIDTH-1:0] DAD;
  logic                 MREQ;
  logic                 WRITE;
  logic [1:0]           SIZE;
  logic                 ACKD_n;

  modport master (
    output DAD,
    output MREQ,
    output WRITE,
    output SIZE,
    input  ACKD_n
  );

  modport slave (
    input  DAD,
    input  MREQ,
    input  WRITE,
    input  SIZE,
    output ACKD_n
  );
endinterface

// File: rtl/dmem_bus_if.sv
// Data-memory bus master: one pipeline load/store becomes one bus transaction,
// with misalignment rejection, wait-cycle timeout and load-data extension.
module dmem_bus_if #(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 stall,
  output logic                 rsp_valid,
  output logic [BIT_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  dmem_bus_if_if.master        bus,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] addr_q, addr_d;
  logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic                 write_q, write_d;
  logic                 signed_q, signed_d;
  logic                 err_q, err_d;
  logic [1:0]           size_q, size_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] ext_rdata;
  logic                 misaligned;

  assign misaligned = ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'b01) && req_addr[0]);

  always_comb begin
    ext_rdata = DDT;
    case (size_q)
      2'b00:   ext_rdata = DDT;
      2'b01:   ext_rdata = {{(BIT_WIDTH-16){signed_q & DDT[15]}}, DDT[15:0]};
      default: ext_rdata = {{(BIT_WIDTH-8){signed_q & DDT[7]}}, DDT[7:0]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    write_d  = write_q;
    signed_d = signed_q;
    err_d    = err_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          write_d  = req_write;
          signed_d = req_signed;
          size_d   = (req_size == 2'b11) ? 2'b10 : req_size;
          rdata_d  = '0;
          err_d    = misaligned;
          state_d  = misaligned ? StResp : StBus;
        end
      end
      StBus: begin
        // Acknowledge takes priority over a timeout expiring on the same edge.
        if (!bus.ACKD_n) begin
          err_d   = 1'b0;
          state_d = StResp;
          if (!write_q) rdata_d = ext_rdata;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if ((TIMEOUT_CYCLES != 0) && (cnt_d == TimeoutVal)) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign stall     = (req_valid && !req_ready) || (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = (state_q == StResp) ? rdata_q : '0;
  assign rsp_err   = (state_q == StResp) && err_q;

  assign bus.DAD   = addr_q;
  assign bus.MREQ  = (state_q == StBus);
  assign bus.WRITE = write_q;
  assign bus.SIZE  = size_q;

  assign DDT = ((state_q == StBus) && write_q) ? wdata_q : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if: vector table of bus transactions plus
// hand-written reset and idle-acknowledge sequences.
module tb_dmem_bus_if;
  localparam logic [31:0] Probe = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ack_n = 1'b1;
  logic [31:0] mem_rd = '0;
  wire  [31:0] ddt;

  int checks = 0;
  int errors = 0;

  dmem_bus_if_if #(.BIT_WIDTH(32)) bus ();

  assign bus.ACKD_n = ack_n;
  // Memory side: read data during load cycles, a probe pattern whenever the bus is idle.
  assign ddt = (!bus.MREQ) ? Probe : (bus.WRITE ? 32'bz : mem_rd);

  dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus        (bus),
    .DDT        (ddt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          ack_at;   // MREQ cycle index with ACKD_n low; -1 = never
    logic        mis;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_size;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_rd     = v.mem;
    check($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
    check($sformatf("v%0d stall_idle", idx), {31'b0, stall}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.mis) begin
      check($sformatf("v%0d mis_mreq", idx), {31'b0, bus.MREQ}, 32'd0);
    end else begin
      n = (v.ack_at < 0) ? 4 : v.ack_at + 1;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        check($sformatf("v%0d mreq[%0d]", idx, k), {31'b0, bus.MREQ}, 32'd1);
        check($sformatf("v%0d dad[%0d]", idx, k), bus.DAD, v.addr);
        check($sformatf("v%0d write[%0d]", idx, k), {31'b0, bus.WRITE}, {31'b0, v.wr});
        check($sformatf("v%0d size[%0d]", idx, k), {30'b0, bus.SIZE}, {30'b0, v.exp_size});
        check($sformatf("v%0d stall_bus[%0d]", idx, k), {31'b0, stall}, 32'd1);
        if (v.wr) check($sformatf("v%0d ddt[%0d]", idx, k), ddt, v.wdata);
        ack_n = (k == v.ack_at) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      ack_n = 1'b1;
      check($sformatf("v%0d resp_mreq", idx), {31'b0, bus.MREQ}, 32'd0);
    end
    check($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
    check($sformatf("v%0d rsp_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
    check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d ddt_released", idx), ddt, Probe);
    @(negedge clk);
    check($sformatf("v%0d rsp_pulse", idx), {31'b0, rsp_valid}, 32'd0);
    check($sformatf("v%0d ready_again", idx), {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    //         wr    size   sgn   addr          wdata         mem           ack mis  err   rdata         size
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'b00};
    vecs[1]  = '{1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0,        32'h0000_0080, 0, 1'b0, 1'b0, 32'hFFFF_FF80, 2'b10};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0,        32'h0000_0080, 0, 1'b0, 1'b0, 32'h0000_0080, 2'b10};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0800_0002, 32'h0,        32'h0000_8001, 0, 1'b0, 1'b0, 32'hFFFF_8001, 2'b01};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0800_0006, 32'h0,        32'hABCD_8001, 1, 1'b0, 1'b0, 32'h0000_8001, 2'b01};
    vecs[5]  = '{1'b0, 2'b11, 1'b1, 32'h0800_0001, 32'h0,        32'h1234_56FE, 0, 1'b0, 1'b0, 32'hFFFF_FFFE, 2'b10};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h0800_0004, 32'h1234_5678, 32'h0,        3, 1'b0, 1'b0, 32'h0,        2'b00};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h0,        2'b00};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0800_0001, 32'h0000_BEEF, 32'h0,        0, 1'b1, 1'b1, 32'h0,        2'b01};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h0000_00AB, 32'h0,        1, 1'b0, 1'b0, 32'h0,        2'b10};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h0800_0020, 32'h0,        32'h1111_2222, -1, 1'b0, 1'b1, 32'h0,       2'b00};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0800_0024, 32'h0,        32'hCAFE_F00D, 3, 1'b0, 1'b0, 32'hCAFE_F00D, 2'b00};
    vecs[12] = '{1'b1, 2'b00, 1'b0, 32'h0800_0028, 32'h8765_4321, 32'h0,       -1, 1'b0, 1'b1, 32'h0,       2'b00};

    // Reset values.
    #12;
    check("rst_mreq", {31'b0, bus.MREQ}, 32'd0);
    check("rst_write", {31'b0, bus.WRITE}, 32'd0);
    check("rst_size", {30'b0, bus.SIZE}, 32'd0);
    check("rst_dad", bus.DAD, 32'd0);
    check("rst_ddt", ddt, Probe);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    // Acknowledge while idle must not start or complete anything.
    ack_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ack_n = 1'b1;
    check("idle_ack_mreq", {31'b0, bus.MREQ}, 32'd0);
    check("idle_ack_rsp", {31'b0, rsp_valid}, 32'd0);

    for (int i = 0; i < 13; i++) run_txn(vecs[i], i);

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h0800_0030;
    req_wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_mreq", {31'b0, bus.MREQ}, 32'd1);
    check("mid_ddt", ddt, 32'hA5A5_0F0F);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_mreq", {31'b0, bus.MREQ}, 32'd0);
    check("mid_rst_ddt", ddt, Probe);
    check("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rsp", {31'b0, rsp_valid}, 32'd0);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_dad", bus.DAD, 32'd0);
    run_txn(vecs[0], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
